// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, field-width functions and address helper for nway_writeback_cache
package cache_pkg;

  typedef enum logic [1:0] {LOOKUP, EVICT, REFILL, RESPOND} state_t;

  function automatic int offset_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_width, input int data_width,
                               input int num_sets, input int words_per_line);
    return addr_width - index_w(num_sets) - word_w(words_per_line) - offset_w(data_width);
  endfunction

  // Zero-width fields come back as 0, which lets WORDS_PER_LINE=1 share the same code path.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/nway_writeback_cache_plru_tree.sv
// rtl/nway_writeback_cache_plru_tree.sv - tree pseudo-LRU victim select and update for one set
module plru_tree #(
  parameter int NUM_WAYS = 2,
  parameter int PW       = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1,
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic [PW-1:0]       plru_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    used_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic [PW-1:0]       plru_o
);

  localparam int LEVELS = $clog2(NUM_WAYS);

  logic [7:0] bits_in;
  logic [7:0] bits_nx;
  logic [2:0] node;
  logic [2:0] tree_way;
  logic [2:0] used_sh;
  logic [2:0] victim;
  logic       dir;

  // Heap-ordered nodes: bit 0 sends the victim left, bit 1 sends it right.
  always_comb begin
    bits_in  = 8'(plru_i);
    bits_nx  = bits_in;
    tree_way = '0;
    dir      = 1'b0;
    node     = '0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      dir      = bits_in[node];
      tree_way = {tree_way[1:0], dir};
      node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
    end
    node    = '0;
    used_sh = 3'(used_i) << (3 - LEVELS);
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      dir           = used_sh[2];
      bits_nx[node] = ~dir;
      node          = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      used_sh       = used_sh << 1;
    end
    victim = tree_way;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim = 3'(w);
    end
    victim_o = victim[WAY_W-1:0];
    plru_o   = bits_nx[PW-1:0];
  end

endmodule

// File: rtl/nway_writeback_cache.sv
// rtl/nway_writeback_cache.sv - N-way set-associative write-back write-allocate cache with line evict/refill
module nway_writeback_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int NUM_WAYS       = 2,
  parameter int NUM_SETS       = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      we,
  input  logic                      addr_mode,
  input  logic [RAM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     wd,
  output logic [DATA_WIDTH-1:0]     rd,
  output logic                      stall,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wd,
  input  logic [DATA_WIDTH-1:0]     ram_rd,
  input  logic                      ram_ack
);

  localparam int OFF_W   = offset_w(DATA_WIDTH);
  localparam int WORD_W  = word_w(WORDS_PER_LINE);
  localparam int INDEX_W = index_w(NUM_SETS);
  localparam int TAG_W   = tag_w(RAM_ADDR_WIDTH, DATA_WIDTH, NUM_SETS, WORDS_PER_LINE);
  localparam int WB      = (WORD_W > 0) ? WORD_W : 1;
  localparam int OBW     = (OFF_W > 0) ? OFF_W : 1;
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PW      = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam int AW      = RAM_ADDR_WIDTH;
  localparam int DW      = DATA_WIDTH;

  logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
  logic [DW-1:0]       data_q  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [PW-1:0]       plru_q  [NUM_SETS];

  state_t             state_q, state_d;
  logic [WB-1:0]      beat_q, beat_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_W-1:0] req_idx_q, req_idx_d;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_idx, idx_sel;
  logic [WB-1:0]       word_sel;
  logic [OBW-1:0]      byte_sel;
  logic [OBW+2:0]      byte_sh;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit, last_beat;
  logic [WAY_W-1:0]    hit_way, way_sel, used_way, plru_victim;
  logic [PW-1:0]       plru_next;
  logic [DW-1:0]       line_word, load_word, merged_word;

  function automatic logic [AW-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                              input logic [INDEX_W-1:0] i,
                                              input logic [WB-1:0] b);
    return (AW'(t) << (INDEX_W + WORD_W + OFF_W)) | (AW'(i) << (WORD_W + OFF_W)) | (AW'(b) << OFF_W);
  endfunction

  assign addr_tag  = TAG_W'(addr_field(64'(addr), OFF_W + WORD_W + INDEX_W, TAG_W));
  assign addr_idx  = INDEX_W'(addr_field(64'(addr), OFF_W + WORD_W, INDEX_W));
  assign word_sel  = WB'(addr_field(64'(addr), OFF_W, WORD_W));
  assign byte_sel  = OBW'(addr_field(64'(addr), 0, OFF_W));
  assign byte_sh   = {byte_sel, 3'b000};
  assign last_beat = (beat_q == WB'(WORDS_PER_LINE - 1));

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[addr_idx][w] && (tag_q[w][addr_idx] == addr_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    hit = |hit_vec;
  end

  // One shared read port: the hit way in LOOKUP, the freshly filled way in RESPOND.
  assign idx_sel     = (state_q == LOOKUP) ? addr_idx : req_idx_q;
  assign way_sel     = (state_q == RESPOND) ? victim_q : hit_way;
  assign used_way    = way_sel;
  assign line_word   = data_q[way_sel][idx_sel][word_sel];
  assign load_word   = addr_mode ? ((line_word >> byte_sh) & DW'(8'hFF)) : line_word;
  assign merged_word = addr_mode ? ((line_word & ~(DW'(8'hFF) << byte_sh)) | (DW'(wd[7:0]) << byte_sh))
                                 : wd;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .plru_i   (plru_q[idx_sel]),
    .valid_i  (valid_q[idx_sel]),
    .used_i   (used_way),
    .victim_o (plru_victim),
    .plru_o   (plru_next)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    victim_d  = victim_q;
    req_tag_d = req_tag_q;
    req_idx_d = req_idx_q;
    stall     = 1'b0;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wd    = '0;
    rd        = '0;
    unique case (state_q)
      LOOKUP: begin
        if (en) begin
          if (hit) begin
            rd = load_word;
          end else begin
            stall     = 1'b1;
            victim_d  = plru_victim;
            req_tag_d = addr_tag;
            req_idx_d = addr_idx;
            beat_d    = '0;
            state_d   = (valid_q[addr_idx][plru_victim] && dirty_q[addr_idx][plru_victim]) ? EVICT : REFILL;
          end
        end
      end
      EVICT: begin
        stall    = 1'b1;
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = beat_addr(tag_q[victim_q][req_idx_q], req_idx_q, beat_q);
        ram_wd   = data_q[victim_q][req_idx_q][beat_q];
        if (ram_ack) begin
          beat_d  = last_beat ? '0 : beat_q + WB'(1);
          state_d = last_beat ? REFILL : EVICT;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        ram_req  = 1'b1;
        ram_addr = beat_addr(req_tag_q, req_idx_q, beat_q);
        if (ram_ack) begin
          beat_d  = last_beat ? '0 : beat_q + WB'(1);
          state_d = last_beat ? RESPOND : REFILL;
        end
      end
      RESPOND: begin
        if (en) rd = load_word;
        state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOOKUP;
      beat_q    <= '0;
      victim_q  <= '0;
      req_tag_q <= '0;
      req_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      victim_q  <= victim_d;
      req_tag_q <= req_tag_d;
      req_idx_q <= req_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state_q == LOOKUP && en && hit) begin
        plru_q[addr_idx] <= plru_next;
        if (we) dirty_q[addr_idx][hit_way] <= 1'b1;
      end
      if (state_q == REFILL && ram_ack && last_beat) begin
        valid_q[req_idx_q][victim_q] <= 1'b1;
        dirty_q[req_idx_q][victim_q] <= 1'b0;
      end
      if (state_q == RESPOND && en) begin
        plru_q[req_idx_q] <= plru_next;
        if (we) dirty_q[req_idx_q][victim_q] <= 1'b1;
      end
    end
  end

  // Tag and data contents need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && en && hit && we)
      data_q[hit_way][addr_idx][word_sel] <= merged_word;
    if (state_q == REFILL && ram_ack) begin
      data_q[victim_q][req_idx_q][beat_q] <= ram_rd;
      if (last_beat) tag_q[victim_q][req_idx_q] <= req_tag_q;
    end
    if (state_q == RESPOND && en && we)
      data_q[victim_q][req_idx_q][word_sel] <= merged_word;
  end

endmodule

// File: tb/tb_nway_writeback_cache.sv
// tb/tb_nway_writeback_cache.sv - directed self-checking bench for nway_writeback_cache
module tb_nway_writeback_cache;

  logic        clk = 1'b0;
  logic        rst, en, we, addr_mode, ram_ack;
  logic [31:0] addr, wd;
  logic [31:0] rd, ram_addr, ram_wd, ram_rd;
  logic        stall, ram_req, ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  nway_writeback_cache #(
    .DATA_WIDTH(32), .RAM_ADDR_WIDTH(32), .NUM_WAYS(2), .NUM_SETS(4), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr_mode(addr_mode), .addr(addr), .wd(wd),
    .rd(rd), .stall(stall), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wd(ram_wd), .ram_rd(ram_rd), .ram_ack(ram_ack)
  );

  // RAM model: every word reads back as its own address.
  assign ram_rd = ram_addr;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic m, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr_mode = m; addr = a; wd = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; we = 1'b0; addr_mode = 1'b0; addr = '0; wd = '0; ram_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({stall, ram_req, ram_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: stall/req/we=%b want 000", {stall, ram_req, ram_we});
    end
    n_checks++;
    if (ram_addr !== 32'h0 || ram_wd !== 32'h0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: ram_addr=%h ram_wd=%h rd=%h want 0", ram_addr, ram_wd, rd);
    end
  endtask

  task automatic test_refill_then_hit();
    drive(1, 0, 0, 32'h40, 0);
    n_checks++;
    if (stall !== 1'b1 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL miss_stall: stall=%b req=%b want 1 0", stall, ram_req);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'(32'h40 + 4 * b) || stall !== 1'b1) begin
        n_fail++;
        $display("FAIL refill_beat%0d: req=%b we=%b addr=%h stall=%b want 1 0 %h 1",
                 b, ram_req, ram_we, ram_addr, stall, 32'(32'h40 + 4 * b));
      end
      tick();
    end
    n_checks++;
    if (stall !== 1'b0 || rd !== 32'h40 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL respond_rd: stall=%b rd=%h req=%b want 0 00000040 0", stall, rd, ram_req);
    end
    tick();
    drive(1, 0, 0, 32'h48, 0);
    n_checks++;
    if (stall !== 1'b0 || rd !== 32'h48 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL hit_0x48: stall=%b rd=%h req=%b want 0 00000048 0", stall, rd, ram_req);
    end
    tick();
  endtask

  task automatic test_store_hit();
    drive(1, 1, 0, 32'h40, 32'hDEADBEEF);
    n_checks++;
    if (stall !== 1'b0 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL store_hit: stall=%b req=%b want 0 0", stall, ram_req);
    end
    tick();
    drive(1, 0, 0, 32'h40, 0);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_readback: rd=%h want deadbeef", rd);
    end
    tick();
    drive(1, 1, 1, 32'h41, 32'h000000AB);
    tick();
    drive(1, 0, 0, 32'h40, 0);
    n_checks++;
    if (rd !== 32'hDEADABEF || stall !== 1'b0) begin
      n_fail++; $display("FAIL byte_store: rd=%h stall=%b want deadabef 0", rd, stall);
    end
    tick();
    drive(1, 0, 1, 32'h43, 0);
    n_checks++;
    if (rd !== 32'h000000DE) begin
      n_fail++; $display("FAIL byte_load: rd=%h want 000000de", rd);
    end
    tick();
  endtask

  task automatic test_evict();
    drive(1, 0, 0, 32'h00, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'(4 * b)) begin
        n_fail++; $display("FAIL fill0_beat%0d: req=%b we=%b addr=%h", b, ram_req, ram_we, ram_addr);
      end
      tick();
    end
    n_checks++;
    if (rd !== 32'h0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL fill0_rd: rd=%h stall=%b want 0 0", rd, stall);
    end
    tick();
    drive(1, 0, 0, 32'h80, 0);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL evict_miss_stall: stall=%b want 1", stall);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      logic [31:0] exp_wd;
      exp_wd = (b == 0) ? 32'hDEADABEF : 32'(32'h40 + 4 * b);
      n_checks++;
      if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'(32'h40 + 4 * b) || ram_wd !== exp_wd || stall !== 1'b1) begin
        n_fail++;
        $display("FAIL evict_beat%0d: req=%b we=%b addr=%h wd=%h want we=1 addr=%h wd=%h",
                 b, ram_req, ram_we, ram_addr, ram_wd, 32'(32'h40 + 4 * b), exp_wd);
      end
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'(32'h80 + 4 * b) || stall !== 1'b1) begin
        n_fail++; $display("FAIL evict_refill_beat%0d: req=%b we=%b addr=%h", b, ram_req, ram_we, ram_addr);
      end
      tick();
    end
    n_checks++;
    if (rd !== 32'h80 || stall !== 1'b0) begin
      n_fail++; $display("FAIL evict_rd: rd=%h stall=%b want 00000080 0", rd, stall);
    end
    tick();
  endtask

  task automatic test_slow_ack();
    drive(1, 0, 0, 32'h44, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 3; c++) begin
        ram_ack = (c == 2);
        #1;
        n_checks++;
        if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'(32'h40 + 4 * b) || stall !== 1'b1) begin
          n_fail++;
          $display("FAIL slow_beat%0d_cyc%0d: req=%b we=%b addr=%h stall=%b want 1 0 %h 1",
                   b, c, ram_req, ram_we, ram_addr, stall, 32'(32'h40 + 4 * b));
        end
        tick();
      end
    end
    ram_ack = 1'b1;
    #1;
    n_checks++;
    if (rd !== 32'h44 || stall !== 1'b0) begin
      n_fail++; $display("FAIL slow_rd: rd=%h stall=%b want 00000044 0", rd, stall);
    end
    tick();
    drive(1, 0, 0, 32'h4C, 0);
    n_checks++;
    if (rd !== 32'h4C || stall !== 1'b0 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL slow_fill_hit: rd=%h stall=%b req=%b want 0000004c 0 0", rd, stall, ram_req);
    end
    tick();
  endtask

  task automatic test_reset_mid_refill();
    drive(1, 0, 0, 32'h00, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h04) begin
      n_fail++; $display("FAIL midrst_beat1: req=%b addr=%h want 1 00000004", ram_req, ram_addr);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 32'h00, 0);
    n_checks++;
    if (ram_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: req=%b stall=%b want 0 0", ram_req, stall);
    end
    drive(1, 0, 0, 32'h40, 0);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL midrst_remiss: stall=%b want 1", stall);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'(32'h40 + 4 * b)) begin
        n_fail++; $display("FAIL midrst_beat%0d: req=%b we=%b addr=%h", b, ram_req, ram_we, ram_addr);
      end
      tick();
    end
    n_checks++;
    if (rd !== 32'h40 || stall !== 1'b0) begin
      n_fail++; $display("FAIL midrst_rd: rd=%h stall=%b want 00000040 0", rd, stall);
    end
    tick();
  endtask

  task automatic test_en_drop();
    drive(1, 0, 0, 32'h84, 0);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL endrop_miss: stall=%b want 1", stall);
    end
    tick();
    drive(0, 0, 0, 32'h84, 0);
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (ram_req !== 1'b1 || ram_addr !== 32'(32'h80 + 4 * b) || stall !== 1'b1) begin
        n_fail++; $display("FAIL endrop_beat%0d: req=%b addr=%h stall=%b", b, ram_req, ram_addr, stall);
      end
      tick();
    end
    n_checks++;
    if (rd !== 32'h0 || stall !== 1'b0 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL endrop_respond: rd=%h stall=%b req=%b want 0 0 0", rd, stall, ram_req);
    end
    tick();
    drive(1, 0, 0, 32'h84, 0);
    n_checks++;
    if (rd !== 32'h84 || stall !== 1'b0 || ram_req !== 1'b0) begin
      n_fail++; $display("FAIL endrop_hit: rd=%h stall=%b req=%b want 00000084 0 0", rd, stall, ram_req);
    end
    tick();
    drive(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_refill_then_hit();
    test_store_hit();
    test_evict();
    test_slow_ack();
    test_reset_mid_refill();
    test_en_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nway_writeback_cache.md
Name: nway_writeback_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines.
- Sits between the memory stage and main RAM; replaces the fixed 2-way, single-word-line cache.
- Adds configurable ways, sets and line size, plus tree pseudo-LRU replacement.
- Adds a multi-cycle RAM handshake with a stall output for line evict and line refill.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- RAM_ADDR_WIDTH, 32: byte address width.
- NUM_WAYS, 2: associativity; power of 2, range 1..8.
- NUM_SETS, 256: sets; power of 2, at least 2.
- WORDS_PER_LINE, 4: words per line; power of 2, at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  access request; inputs are held stable while stall=1.
- we  in  1  store when 1, load when 0.
- addr_mode  in  1  0 = word access; 1 = byte access (load zero-extended, store one byte).
- addr  in  RAM_ADDR_WIDTH  byte address. Split is tag | index | word-in-line | byte offset.
- wd  in  DATA_WIDTH  store data; byte store uses wd[7:0].
- rd  out  DATA_WIDTH  load data; valid when en=1 and stall=0, otherwise 0.
- stall  out  1  access not yet complete.
- ram_req  out  1  RAM beat request.
- ram_we  out  1  1 = write beat (evict), 0 = read beat (refill).
- ram_addr  out  RAM_ADDR_WIDTH  word-aligned beat address.
- ram_wd  out  DATA_WIDTH  evicted word.
- ram_rd  in  DATA_WIDTH  refill word; valid when ram_ack=1 on a read beat.
- ram_ack  in  1  beat completes this cycle.

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - Clears all valid, dirty and PLRU bits in one cycle; FSM goes to LOOKUP.
  - Outputs after reset: stall=0, ram_req=0, ram_we=0, ram_addr=0, ram_wd=0, rd=0.
  - Reset mid-evict or mid-refill aborts the transfer: ram_req=0 after that edge and dirty data is discarded.
- Storage: tag, valid, dirty and data arrays are register-based with combinational read.
- PLRU: NUM_WAYS-1 bits per set, updated on every completed access (hit, or refill response) to point away from the used way.
- LOOKUP state:
  - Idle (en=0): stall=0, no array changes.
  - Hit: completes in the same cycle; stall=0 and rd is driven combinationally.
  - Store hit: writes the word or byte at the edge, sets dirty, updates PLRU.
  - Miss: stall=1 combinationally in that cycle.
  - Victim: the lowest-index invalid way; otherwise the PLRU way.
  - Next state: EVICT if the victim is valid and dirty, else REFILL. The beat counter is cleared.
- EVICT state:
  - Drives ram_req=1, ram_we=1, ram_addr = {victim tag, index, beat, 00}, ram_wd = victim word[beat].
  - Each ram_ack advances beat. After beat WORDS_PER_LINE-1 acks, go to REFILL with the counter cleared.
- REFILL state:
  - Drives ram_req=1, ram_we=0, ram_addr = {req tag, index, beat, 00}.
  - On ram_ack, writes ram_rd into victim word[beat].
  - On the last beat: writes the tag, sets valid=1 and dirty=0, then goes to RESPOND.
- RESPOND state:
  - Exactly one cycle, with stall=0.
  - Load: rd comes from the filled line.
  - Store: writes and sets dirty. PLRU updates. Returns to LOOKUP.
- Handshake: ram_req, ram_we, ram_addr and ram_wd stay stable until ram_ack is sampled high.
  - Beats are back-to-back when ram_ack=1 every cycle.
  - ram_ack while ram_req=0 is ignored.
- Latency with ram_ack tied high:
  - Hit: 0 extra cycles.
  - Clean miss: WORDS_PER_LINE+1 extra cycles.
  - Dirty miss: 2*WORDS_PER_LINE+1 extra cycles.
- If en drops mid-miss, the transfer still completes. RESPOND then makes no write and no PLRU update, and rd=0.
- NUM_WAYS=1: no PLRU bits; the victim is always way 0.
- WORDS_PER_LINE=1: the word-in-line field has width 0 and each transfer is a single beat.

Decomposition:
- Package cache_pkg holds:
  - the state enum {LOOKUP, EVICT, REFILL, RESPOND};
  - functions deriving OFFSET_W, WORD_W, INDEX_W, TAG_W from the parameters;
  - the address-field extract helper.
- Sub-module plru_tree:
  - Combinational, parameter NUM_WAYS.
  - Inputs: set PLRU bits, valid vector, used way.
  - Outputs: victim way, next PLRU bits.

Test Plan (NUM_WAYS=2, NUM_SETS=4, WORDS_PER_LINE=4; RAM model returns data = address; ram_ack=1 unless stated):
- After reset, load word at 0x40. Expect stall=1, then read beats at 0x40, 0x44, 0x48, 0x4C, then a RESPOND cycle with rd=0x40. A following load at 0x48 gives rd=0x48 with stall=0 and no ram_req.
- Store 0xDEADBEEF to 0x40 (hit): no RAM traffic, load returns 0xDEADBEEF. Byte store 0xAB to 0x41 (addr_mode=1): word load returns 0xDEADABEF. Byte load at 0x43 returns 0x000000DE.
- Load 0x00 after the steps above: miss fills way 1, and the 0x00 line becomes most recent. Then load 0x80 (set 0): the victim is the dirty 0x40 line. Expect write beats at 0x40..0x4C with data 0xDEADABEF, 0x44, 0x48, 0x4C, then read beats at 0x80..0x8C, rd=0x80.
- ram_ack raised only every 3rd cycle during a refill: ram_addr and ram_we hold stable across the wait cycles, stall stays 1, and the filled data is correct.
- rst asserted on the second refill beat: ram_req=0 after that edge, stall=0. Reloading 0x40 misses again and issues 4 read beats.
- en dropped after the miss cycle: the refill completes with rd=0. A later load at the same address hits with no RAM traffic.
